// File: rtl/uart_xcvr.sv
// uart_xcvr: single-clock full-duplex UART transceiver.
//
// Character length, parity and stop-bit count are parameters. Everything runs
// on clk. A free-running divider produces a 16x-baud tick for the receiver. The
// transmitter times its bits with its own cycle counter. That counter restarts
// when a request is accepted, so the first edge of a transmit frame does not
// depend on tick phase.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous reset, active low
//   rx         serial input (asynchronous to clk)
//   dintx      transmit data, bits [DATA_BITS-1:0] used
//   newd       transmit request
//   tx         serial output (idle high)
//   txbusy     transmitter busy
//   donetx     1-cycle pulse on the final clock of the last stop bit
//   doutrx     received character, right-aligned, upper bits zero
//   donerx     1-cycle pulse when a character has been received
//   parity_err parity mismatch of the last character (valid with donerx)
//   frame_err  first stop bit sampled low (valid with donerx)
//   tx_state   transmit FSM state (debug)
//   rx_state   receive FSM state (debug)
//
// Transmit handshake: newd is sampled on every clock. It is accepted only while
// txbusy is low. The accepting clock latches dintx. txbusy rises on the next
// clock and stays high through the donetx cycle. A newd while txbusy is high
// is dropped, not queued.
module uart_xcvr #(
  parameter int CLK_FREQ  = 1000000,
  parameter int BAUD_RATE = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic [7:0] dintx,
  input  logic       newd,
  output logic       tx,
  output logic       txbusy,
  output logic       donetx,
  output logic [7:0] doutrx,
  output logic       donerx,
  output logic       parity_err,
  output logic       frame_err,
  output logic [2:0] tx_state,
  output logic [2:0] rx_state
);

  localparam int DIV     = CLK_FREQ / (BAUD_RATE * 16);
  localparam int BIT_CYC = 16 * DIV;
  localparam int TW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CW      = $clog2(BIT_CYC + 1);

  localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
  localparam logic [CW-1:0] CYC_LAST  = CW'(BIT_CYC - 1);
  localparam logic [2:0]    BIT_LAST  = 3'(DATA_BITS - 1);
  localparam logic          STOP_LAST = (STOP_BITS == 2);
  localparam logic [7:0]    DMASK     = 8'((1 << DATA_BITS) - 1);

  // Parity bit for a character: even parity is the XOR of the data bits,
  // and odd parity is its inverse.
  function automatic logic calc_par(input logic [7:0] d);
    logic e;
    e = ^(d & DMASK);
    return (PARITY == 1) ? ~e : e;
  endfunction

  // ---------------------------------------------------------------------------
  // 16x baud tick
  // ---------------------------------------------------------------------------
  logic [TW-1:0] tick_cnt;
  logic          tick;

  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Transmitter
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_t;

  tx_state_t     tx_st, tx_st_n;
  logic [CW-1:0] tx_cyc, tx_cyc_n;
  logic [2:0]    tx_bit, tx_bit_n;
  logic          tx_stop, tx_stop_n;
  logic [7:0]    tx_sh, tx_sh_n;
  logic          tx_par, tx_par_n;
  logic          tx_q, tx_n;
  logic          tx_bit_end;

  assign tx_bit_end = (tx_cyc == CYC_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_st   <= TX_IDLE;
      tx_cyc  <= '0;
      tx_bit  <= '0;
      tx_stop <= 1'b0;
      tx_sh   <= '0;
      tx_par  <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      tx_st   <= tx_st_n;
      tx_cyc  <= tx_cyc_n;
      tx_bit  <= tx_bit_n;
      tx_stop <= tx_stop_n;
      tx_sh   <= tx_sh_n;
      tx_par  <= tx_par_n;
      tx_q    <= tx_n;
    end
  end

  // The tx line is registered. Each transition computes the level of the
  // next bit, so the line changes on the same clock as the state.
  always_comb begin
    tx_st_n   = tx_st;
    tx_cyc_n  = tx_cyc;
    tx_bit_n  = tx_bit;
    tx_stop_n = tx_stop;
    tx_sh_n   = tx_sh;
    tx_par_n  = tx_par;
    tx_n      = tx_q;
    case (tx_st)
      TX_IDLE: begin
        tx_n = 1'b1;
        if (newd) begin
          tx_st_n  = TX_START;
          tx_cyc_n = '0;
          tx_sh_n  = dintx;
          tx_par_n = calc_par(dintx);
          tx_n     = 1'b0;
        end
      end
      TX_START: begin
        if (tx_bit_end) begin
          tx_st_n  = TX_DATA;
          tx_cyc_n = '0;
          tx_bit_n = '0;
          tx_n     = tx_sh[0];
        end else begin
          tx_cyc_n = tx_cyc + 1'b1;
        end
      end
      TX_DATA: begin
        if (tx_bit_end) begin
          tx_cyc_n = '0;
          if (tx_bit == BIT_LAST) begin
            if (PARITY != 0) begin
              tx_st_n = TX_PARITY;
              tx_n    = tx_par;
            end else begin
              tx_st_n   = TX_STOP;
              tx_stop_n = 1'b0;
              tx_n      = 1'b1;
            end
          end else begin
            tx_bit_n = tx_bit + 1'b1;
            tx_sh_n  = tx_sh >> 1;
            tx_n     = tx_sh[1];
          end
        end else begin
          tx_cyc_n = tx_cyc + 1'b1;
        end
      end
      TX_PARITY: begin
        if (tx_bit_end) begin
          tx_st_n   = TX_STOP;
          tx_cyc_n  = '0;
          tx_stop_n = 1'b0;
          tx_n      = 1'b1;
        end else begin
          tx_cyc_n = tx_cyc + 1'b1;
        end
      end
      TX_STOP: begin
        if (tx_bit_end) begin
          tx_cyc_n = '0;
          tx_n     = 1'b1;
          if (tx_stop == STOP_LAST) tx_st_n = TX_IDLE;
          else                      tx_stop_n = tx_stop + 1'b1;
        end else begin
          tx_cyc_n = tx_cyc + 1'b1;
        end
      end
      default: begin
        tx_st_n = TX_IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end

  assign tx       = tx_q;
  assign txbusy   = (tx_st != TX_IDLE);
  assign donetx   = (tx_st == TX_STOP) && tx_bit_end && (tx_stop == STOP_LAST);
  assign tx_state = tx_st;

  // ---------------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_PARITY    = 3'd3,
    RX_STOP      = 3'd4,
    RX_WAIT_HIGH = 3'd5
  } rx_state_t;

  logic [1:0]           rx_sync;
  logic                 rxs;
  rx_state_t            rx_st, rx_st_n;
  logic [3:0]           rx_tcnt, rx_tcnt_n;
  logic [2:0]           rx_bit, rx_bit_n;
  logic [DATA_BITS-1:0] rx_sh, rx_sh_n;
  logic                 rx_perr, rx_perr_n;
  logic [7:0]           dout_q, dout_n;
  logic                 donerx_q, donerx_n;
  logic                 perr_q, perr_n;
  logic                 ferr_q, ferr_n;

  assign rxs = rx_sync[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_sync  <= 2'b11;
      rx_st    <= RX_IDLE;
      rx_tcnt  <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
      rx_perr  <= 1'b0;
      dout_q   <= '0;
      donerx_q <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      rx_sync  <= {rx_sync[0], rx};
      rx_st    <= rx_st_n;
      rx_tcnt  <= rx_tcnt_n;
      rx_bit   <= rx_bit_n;
      rx_sh    <= rx_sh_n;
      rx_perr  <= rx_perr_n;
      dout_q   <= dout_n;
      donerx_q <= donerx_n;
      perr_q   <= perr_n;
      ferr_q   <= ferr_n;
    end
  end

  // A start edge is seen at a tick. It is confirmed 8 ticks later, near the
  // start-bit centre. After that, every 16th tick falls at a bit centre.
  always_comb begin
    rx_st_n   = rx_st;
    rx_tcnt_n = rx_tcnt;
    rx_bit_n  = rx_bit;
    rx_sh_n   = rx_sh;
    rx_perr_n = rx_perr;
    dout_n    = dout_q;
    donerx_n  = 1'b0;
    perr_n    = perr_q;
    ferr_n    = ferr_q;
    if (tick) begin
      case (rx_st)
        RX_IDLE: begin
          if (!rxs) begin
            rx_st_n   = RX_START;
            rx_tcnt_n = '0;
          end
        end
        RX_START: begin
          if (rx_tcnt == 4'd7) begin
            rx_tcnt_n = '0;
            if (rxs) begin
              rx_st_n = RX_IDLE;        // too short to be a start bit
            end else begin
              rx_st_n   = RX_DATA;
              rx_bit_n  = '0;
              rx_perr_n = 1'b0;
            end
          end else begin
            rx_tcnt_n = rx_tcnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_tcnt == 4'd15) begin
            rx_tcnt_n = '0;
            rx_sh_n   = {rxs, rx_sh[DATA_BITS-1:1]};
            if (rx_bit == BIT_LAST) begin
              rx_st_n = (PARITY != 0) ? RX_PARITY : RX_STOP;
            end else begin
              rx_bit_n = rx_bit + 1'b1;
            end
          end else begin
            rx_tcnt_n = rx_tcnt + 1'b1;
          end
        end
        RX_PARITY: begin
          if (rx_tcnt == 4'd15) begin
            rx_tcnt_n = '0;
            rx_perr_n = rxs ^ calc_par(8'(rx_sh));
            rx_st_n   = RX_STOP;
          end else begin
            rx_tcnt_n = rx_tcnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_tcnt == 4'd15) begin
            rx_tcnt_n = '0;
            dout_n    = 8'(rx_sh);
            perr_n    = (PARITY != 0) ? rx_perr : 1'b0;
            ferr_n    = ~rxs;
            donerx_n  = 1'b1;
            // Returning to idle at mid-stop leaves half a bit of margin
            // for a start bit that follows back-to-back.
            rx_st_n   = rxs ? RX_IDLE : RX_WAIT_HIGH;
          end else begin
            rx_tcnt_n = rx_tcnt + 1'b1;
          end
        end
        RX_WAIT_HIGH: begin
          // A break or lost framing: wait for the line to return to idle
          // before looking for the next start bit.
          if (rxs) rx_st_n = RX_IDLE;
        end
        default: rx_st_n = RX_IDLE;
      endcase
    end
  end

  assign doutrx     = dout_q;
  assign donerx     = donerx_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign rx_state   = rx_st;

endmodule
